vector_store_serializer: RTL and testbench
==========================================

Name: vector_store_serializer

Overview:
- Downstream neighbour of the vector memory-loader stage.
- Accepts one 12-bit base address plus one 128-bit packed vector (16 lanes × 8 bits) and writes it into byte-wide data memory, one lane per accepted cycle, at consecutive addresses.
- Drives a busy signal so the execute/memory pipeline stalls while a store is in flight.
- Honours a memory-side ready signal for backpressure.

Parameters:
- ADDR_W, 12, data-memory address width; addresses wrap modulo 2^ADDR_W.
- LANE_W, 8, bits per lane.
- LANES, 16, lanes per vector; vector width = LANES*LANE_W = 128.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- store_start  input  1  request to store the presented vector.
- address_data_vector  input  ADDR_W  base address of the store.
- data_vectorial_out  input  LANES*LANE_W  packed vector; lane 1 is the MSB byte [127:120], lane 16 is [7:0].
- mem_ready  input  1  memory accepts the write presented this cycle.
- mem_addr  output  ADDR_W  byte write address.
- mem_wdata  output  LANE_W  byte write data.
- mem_we  output  1  write strobe.
- busy  output  1  store in progress; pipeline must stall.
- done  output  1  one-cycle pulse, store complete.

Behaviour:
- One clock domain, synchronous active-high reset.
- Reset values: state IDLE, lane counter 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, and the capture registers 0.
- FSM states: IDLE and WRITE.
- IDLE:
  - If store_start=1 at a rising edge, capture address_data_vector and data_vectorial_out into internal registers, clear the lane counter, and go to WRITE.
  - From the next cycle, busy=1 and mem_we=1.
  - Inputs may change freely after the capture edge.
- WRITE outputs (all registered):
  - mem_we=1.
  - mem_addr = base + lane index (0..15), computed modulo 2^ADDR_W. Base 0xFFA wraps to 0x000 after 0xFFF.
  - mem_wdata = captured lane (index+1), i.e. index 0 carries bits [127:120].
- Handshake:
  - A write is committed only on an edge where mem_we=1 and mem_ready=1.
  - With mem_ready=0, mem_addr, mem_wdata and mem_we hold unchanged and the counter does not advance.
- Completion:
  - When lane index 15 is committed, go to IDLE.
  - Next cycle: mem_we=0, busy=0, done=1 for exactly one cycle.
- Latency:
  - With mem_ready held at 1, first write appears 1 cycle after the start edge.
  - Last write appears 16 cycles after the start edge; done appears 17 cycles after it.
  - Each ready=0 cycle adds one cycle.
- store_start while in WRITE is ignored. The request is not queued; upstream must hold it until busy=0.
- store_start in the done cycle (state IDLE) is accepted normally, giving back-to-back stores with one idle cycle between write bursts.
- Reset mid-store:
  - Abort on the reset edge; mem_we=0 from the following cycle and done is not asserted.
  - Bytes already committed remain in memory.
- Reset has priority over store_start in the same cycle.

Decomposition:
- Shared package holds:
  - Constants ADDR_W, LANE_W and LANES.
  - A typedef for the packed vector (logic [LANES*LANE_W-1:0]).
  - A typedef for the address.
  - An enum for the FSM state {IDLE, WRITE}.
- One natural sub-module: vector_lane_select. It is purely combinational and selects lane k (MSB-first) from the captured vector. The counter, FSM and output registers stay in the top module.

Test Plan:
- Basic store: base 0x100, vector 0x0102…0F10 (lane n = n), ready tied 1 -> writes 0x100←0x01 … 0x10F←0x10 on consecutive cycles; done at start+17; busy high cycles 1–16 after start.
- Backpressure: same store, mem_ready=0 on the 3rd and 4th write cycles -> address 0x102/data 0x03 held for 3 cycles total; no skipped or duplicated byte; done at start+19.
- Wrap-around: base 0xFFA -> the 16 addresses are 0xFFA…0xFFF then 0x000…0x009, data in lane order.
- Ignored and back-to-back start:
  - store_start pulsed mid-burst with base 0x200 -> ignored, the first store completes untouched.
  - store_start in the done cycle with base 0x300 -> second burst starts the next cycle at 0x300.
- Reset mid-operation: rst asserted after the 5th commit -> mem_we=0, busy=0 the next cycle, no done pulse, exactly 5 bytes written; a new store after reset behaves normally.
- Input change after capture: alter data_vectorial_out and address_data_vector one cycle after the start edge -> written bytes and addresses still match the captured values.

Source files
------------

// File: rtl/vector_store_serializer_pkg.sv
// Shared widths, types and FSM state encoding for the vector store serializer.
// Lanes are numbered MSB-first: lane index 0 is the top byte of the packed vector.
package vector_store_serializer_pkg;

    localparam int ADDR_W     = 12;
    localparam int LANE_W     = 8;
    localparam int LANES      = 16;
    localparam int VEC_W      = LANES * LANE_W;
    localparam int LANE_IDX_W = $clog2(LANES);

    typedef logic [VEC_W-1:0]      vec_t;
    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [LANE_W-1:0]     lane_t;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

endpackage

// File: rtl/vector_store_serializer_lane_select.sv
// Combinational MSB-first lane picker: index 0 returns bits [VEC_W-1 -: LANE_W].
module vector_lane_select
    import vector_store_serializer_pkg::*;
(
    input  logic [VEC_W-1:0]      vec_i,
    input  logic [LANE_IDX_W-1:0] idx_i,
    output logic [LANE_W-1:0]     lane_o
);

    always_comb begin
        lane_o = '0;
        for (int k = 0; k < LANES; k++) begin
            if (idx_i == LANE_IDX_W'(k)) begin
                lane_o = vec_i[(LANES-1-k)*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/vector_store_serializer.sv
// Serializes a captured 16-lane vector into byte writes at consecutive (wrapping)
// addresses, holding the write steady under memory backpressure.
module vector_store_serializer
    import vector_store_serializer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              store_start,
    input  logic [ADDR_W-1:0] address_data_vector,
    input  logic [VEC_W-1:0]  data_vectorial_out,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANE_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done
);

    localparam lane_idx_t LAST_IDX = LANE_IDX_W'(LANES - 1);

    state_e    state_q, state_d;
    lane_idx_t laneIdx_q, laneIdx_d;
    addr_t     baseAddr_q, baseAddr_d;
    vec_t      vector_q, vector_d;
    addr_t     memAddr_q, memAddr_d;
    lane_t     memWdata_q, memWdata_d;
    logic      memWe_q, memWe_d;
    logic      busy_q, busy_d;
    logic      done_q, done_d;

    lane_idx_t nextIdx;
    vec_t      selVec;
    lane_idx_t selIdx;
    lane_t     selLane;

    // The first byte is taken straight from the inputs on the capture edge so it
    // is on the bus one cycle after start; later bytes come from the captured copy.
    assign nextIdx = laneIdx_q + 1'b1;
    assign selVec  = (state_q == IDLE) ? data_vectorial_out : vector_q;
    assign selIdx  = (state_q == IDLE) ? '0 : nextIdx;

    vector_lane_select u_lane_select (
        .vec_i  (selVec),
        .idx_i  (selIdx),
        .lane_o (selLane)
    );

    always_comb begin
        state_d    = state_q;
        laneIdx_d  = laneIdx_q;
        baseAddr_d = baseAddr_q;
        vector_d   = vector_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memWe_d    = memWe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (store_start) begin
                    state_d    = WRITE;
                    baseAddr_d = address_data_vector;
                    vector_d   = data_vectorial_out;
                    laneIdx_d  = '0;
                    memAddr_d  = address_data_vector;
                    memWdata_d = selLane;
                    memWe_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            WRITE: begin
                if (memWe_q && mem_ready) begin
                    if (laneIdx_q == LAST_IDX) begin
                        state_d = IDLE;
                        memWe_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        laneIdx_d  = nextIdx;
                        memAddr_d  = baseAddr_q + addr_t'(nextIdx);
                        memWdata_d = selLane;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            laneIdx_q  <= '0;
            baseAddr_q <= '0;
            vector_q   <= '0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memWe_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            laneIdx_q  <= laneIdx_d;
            baseAddr_q <= baseAddr_d;
            vector_q   <= vector_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memWe_q    <= memWe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign mem_we    = memWe_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vector_store_serializer.sv
// Directed bench for vector_store_serializer with a byte-memory model on the write port.
module tb_vector_store_serializer;
    import vector_store_serializer_pkg::*;

    localparam vec_t VEC_A = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam vec_t VEC_B = 128'hA1A2A3A4A5A6A7A8A9AAABACADAEAFB0;

    logic  clk = 1'b0;
    logic  rst;
    logic  store_start;
    addr_t address_data_vector;
    vec_t  data_vectorial_out;
    logic  mem_ready;
    addr_t mem_addr;
    lane_t mem_wdata;
    logic  mem_we;
    logic  busy;
    logic  done;

    int    vectorsApplied = 0;
    int    miscompares    = 0;
    int    writeCount     = 0;
    lane_t memModel [0:4095];

    vector_store_serializer dut (
        .clk                 (clk),
        .rst                 (rst),
        .store_start         (store_start),
        .address_data_vector (address_data_vector),
        .data_vectorial_out  (data_vectorial_out),
        .mem_ready           (mem_ready),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_we              (mem_we),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we && mem_ready) begin
            memModel[mem_addr] <= mem_wdata;
            writeCount         <= writeCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Launches (or continues) one store and checks the bus cycle by cycle.
    task automatic applyStimulus(input string tag, input addr_t base, input vec_t vec,
                                 input logic [63:0] stallMask, input int injectCycle,
                                 input int alterCycle, input bit preStarted, input bit chain,
                                 input addr_t nextBase, input vec_t nextVec, output int doneAt);
        int    idx;
        addr_t expAddr;
        lane_t expData;
        if (!preStarted) begin
            @(negedge clk);
            store_start         = 1'b1;
            address_data_vector = base;
            data_vectorial_out  = vec;
        end
        @(posedge clk);
        idx    = 0;
        doneAt = -1;
        for (int c = 1; c <= 60 && doneAt < 0; c++) begin
            @(negedge clk);
            store_start = (c == injectCycle);
            if (c == injectCycle) address_data_vector = 12'h200;
            if (c == alterCycle) begin
                data_vectorial_out  = ~vec;
                address_data_vector = base ^ 12'h555;
            end
            mem_ready = !stallMask[c];
            if (idx < LANES) begin
                expAddr = base + addr_t'(idx);
                expData = vec[(LANES-1-idx)*LANE_W +: LANE_W];
                checkOutput({tag, "_we"},   128'(mem_we),    128'd1);
                checkOutput({tag, "_busy"}, 128'(busy),      128'd1);
                checkOutput({tag, "_done"}, 128'(done),      128'd0);
                checkOutput({tag, "_addr"}, 128'(mem_addr),  128'(expAddr));
                checkOutput({tag, "_data"}, 128'(mem_wdata), 128'(expData));
                if (mem_ready) idx++;
            end else begin
                checkOutput({tag, "_doneHi"}, 128'(done),   128'd1);
                checkOutput({tag, "_busyLo"}, 128'(busy),   128'd0);
                checkOutput({tag, "_weLo"},   128'(mem_we), 128'd0);
                doneAt = c;
                if (chain) begin
                    store_start         = 1'b1;
                    address_data_vector = nextBase;
                    data_vectorial_out  = nextVec;
                end
            end
        end
        if (doneAt < 0) begin
            checkOutput({tag, "_timeout"}, 128'd0, 128'd1);
        end else if (!chain) begin
            @(negedge clk);
            checkOutput({tag, "_doneOnce"}, 128'(done), 128'd0);
        end
    endtask

    initial begin
        int doneAt;
        int wc0;
        for (int a = 0; a < 4096; a++) memModel[a] = '0;
        rst                 = 1'b1;
        store_start         = 1'b0;
        address_data_vector = '0;
        data_vectorial_out  = '0;
        mem_ready           = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_we",    128'(mem_we),    128'd0);
        checkOutput("rst_busy",  128'(busy),      128'd0);
        checkOutput("rst_done",  128'(done),      128'd0);
        checkOutput("rst_addr",  128'(mem_addr),  128'd0);
        checkOutput("rst_wdata", 128'(mem_wdata), 128'd0);
        rst = 1'b0;

        $display("[TB] basic store at 0x100");
        wc0 = writeCount;
        applyStimulus("basic", 12'h100, VEC_A, 64'd0, 0, 0, 1'b0, 1'b0, 12'h0, '0, doneAt);
        checkOutput("basic_doneAt", 128'(doneAt), 128'd17);
        checkOutput("basic_count",  128'(writeCount - wc0), 128'd16);
        checkOutput("basic_m100",   128'(memModel[12'h100]), 128'h01);
        checkOutput("basic_m10F",   128'(memModel[12'h10F]), 128'h10);

        $display("[TB] backpressure on write cycles 3 and 4");
        wc0 = writeCount;
        applyStimulus("bp", 12'h100, VEC_A, 64'h18, 0, 0, 1'b0, 1'b0, 12'h0, '0, doneAt);
        checkOutput("bp_doneAt", 128'(doneAt), 128'd19);
        checkOutput("bp_count",  128'(writeCount - wc0), 128'd16);

        $display("[TB] wrap-around from 0xFFA");
        applyStimulus("wrap", 12'hFFA, VEC_B, 64'd0, 0, 0, 1'b0, 1'b0, 12'h0, '0, doneAt);
        checkOutput("wrap_doneAt", 128'(doneAt), 128'd17);
        checkOutput("wrap_mFFA",   128'(memModel[12'hFFA]), 128'hA1);
        checkOutput("wrap_mFFF",   128'(memModel[12'hFFF]), 128'hA6);
        checkOutput("wrap_m000",   128'(memModel[12'h000]), 128'hA7);
        checkOutput("wrap_m009",   128'(memModel[12'h009]), 128'hB0);

        $display("[TB] ignored mid-burst start, then back-to-back store");
        applyStimulus("ign", 12'h500, VEC_A, 64'd0, 6, 0, 1'b0, 1'b1, 12'h300, VEC_B, doneAt);
        checkOutput("ign_doneAt", 128'(doneAt), 128'd17);
        applyStimulus("b2b", 12'h300, VEC_B, 64'd0, 0, 0, 1'b1, 1'b0, 12'h0, '0, doneAt);
        checkOutput("b2b_doneAt", 128'(doneAt), 128'd17);
        checkOutput("ign_m200",   128'(memModel[12'h200]), 128'h00);
        checkOutput("ign_m505",   128'(memModel[12'h505]), 128'h06);
        checkOutput("b2b_m300",   128'(memModel[12'h300]), 128'hA1);
        checkOutput("b2b_m30F",   128'(memModel[12'h30F]), 128'hB0);

        $display("[TB] reset after the fifth commit");
        wc0 = writeCount;
        @(negedge clk);
        store_start         = 1'b1;
        address_data_vector = 12'h400;
        data_vectorial_out  = VEC_A;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            store_start = 1'b0;
            mem_ready   = 1'b1;
        end
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b1;
        checkOutput("rmid_we",    128'(mem_we),   128'd0);
        checkOutput("rmid_busy",  128'(busy),     128'd0);
        checkOutput("rmid_addr",  128'(mem_addr), 128'd0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("rmid_noDone", 128'(done), 128'd0);
            @(negedge clk);
        end
        checkOutput("rmid_count", 128'(writeCount - wc0), 128'd5);
        checkOutput("rmid_m404",  128'(memModel[12'h404]), 128'h05);
        checkOutput("rmid_m405",  128'(memModel[12'h405]), 128'h00);

        $display("[TB] inputs altered after capture");
        applyStimulus("alter", 12'h600, VEC_B, 64'd0, 0, 1, 1'b0, 1'b0, 12'h0, '0, doneAt);
        checkOutput("alter_doneAt", 128'(doneAt), 128'd17);
        checkOutput("alter_m600",   128'(memModel[12'h600]), 128'hA1);
        checkOutput("alter_m60F",   128'(memModel[12'h60F]), 128'hB0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
